mem_access_stage: RTL and testbench

- Memory-access stage between the EX/MEM pipeline register and the MEM/WB register.
- Issues data-memory reads and writes over a req/ack handshake. A 4-state FSM tracks each access.
- Freezes upstream stages while an access is outstanding. A watchdog aborts hung accesses.
- Presents a registered load result plus pass-through control to MEM/WB.

---
 rtl/mem_access_stage_pkg.sv | 7 +
 rtl/mem_bus_watchdog.sv | 16 +
 rtl/mem_access_stage.sv | 84 ++++++++
 tb/tb_mem_access_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared widths and FSM encodings for the memory-access stage
package mem_access_stage_pkg;
  localparam int DSIZE = 32;
  localparam int ASIZE = 5;
  localparam int ISIZE = 32;
  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;
endpackage

// File: rtl/mem_bus_watchdog.sv
// mem_bus_watchdog: counts cycles spent waiting on the data bus, flags TIMEOUT-1 reached
module mem_bus_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : en ? cnt + 1'b1 : cnt;
  assign expired = cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM -> MEM/WB data-memory stage with req/ack bus and watchdog abort.
// Define MEM_ALIGN_CHECK_EN to reject misaligned accesses with a misalign_out pulse.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DW      = DSIZE,
  parameter int RAW     = ASIZE,
  parameter int PCW     = ISIZE,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  aluout_in,
  input  logic [DW-1:0]  wdata_in,
  input  logic [RAW-1:0] waddr_in,
  input  logic           wen_in,
  input  logic           memread_in,
  input  logic           memwrite_in,
  input  logic           memtoreg_in,
  input  logic           jal_in,
  input  logic [PCW-1:0] nPC_in,
  output logic           stall_out,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic           dmem_ack,
  input  logic [DW-1:0]  dmem_rdata,
  output logic [RAW-1:0] waddr_out,
  output logic [DW-1:0]  aluout_out,
  output logic [DW-1:0]  memdata_out,
  output logic           wen_out,
  output logic           memtoreg_out,
  output logic           jal_out,
  output logic [PCW-1:0] nPC_out,
  output logic           bus_err_out,
  output logic           misalign_out
);
  state_t state, nxt;
  logic acc, mis, start, busy, squash, expired;
  logic [DW-1:0] load_buf;
  assign acc = memread_in || memwrite_in;
`ifdef MEM_ALIGN_CHECK_EN
  assign mis       = state == IDLE && acc && aluout_in[1:0] != 2'b00;
  assign dmem_addr = aluout_in;
`else
  assign mis       = 1'b0;
  assign dmem_addr = {aluout_in[DW-1:2], 2'b00};
`endif
  assign start = state == IDLE && acc && !mis;
  assign busy  = start || state == WAIT;
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb
    nxt = state == IDLE ? (start ? (dmem_ack ? DONE : WAIT) : IDLE) :
          state == WAIT ? (dmem_ack ? DONE : expired ? ERR : WAIT) : IDLE;
  // stall depends only on state and EX/MEM inputs, never on dmem_ack
  always_comb begin
    squash       = busy || state == ERR || mis;
    stall_out    = busy && !rst;
    dmem_req     = busy && !rst;
    bus_err_out  = state == ERR && !rst;
    misalign_out = mis && !rst;
    wen_out      = wen_in && !squash;
    memtoreg_out = memtoreg_in && !squash;
    jal_out      = jal_in && !squash;
  end
  always_ff @(posedge clk)
    if (rst) load_buf <= '0;
    else if (busy && dmem_ack && memread_in) load_buf <= dmem_rdata;
  mem_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk),
    .rst(rst),
    .clr(nxt != WAIT),
    .en(nxt == WAIT),
    .expired(expired)
  );
  assign dmem_we     = memwrite_in;
  assign dmem_wdata  = wdata_in;
  assign waddr_out   = waddr_in;
  assign aluout_out  = aluout_in;
  assign nPC_out     = nPC_in;
  assign memdata_out = load_buf;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: per-instruction cycle-sequence model with randomized bus latency
module tb_mem_access_stage;
  localparam int DW = 32, RAW = 5, PCW = 32, TIMEOUT = 16;
  logic clk = 0, rst = 1;
  logic [DW-1:0] aluout_in = 0, wdata_in = 0, dmem_rdata = 0;
  logic [RAW-1:0] waddr_in = 0;
  logic [PCW-1:0] nPC_in = 0;
  logic wen_in = 0, memread_in = 0, memwrite_in = 0, memtoreg_in = 0, jal_in = 0, dmem_ack = 0;
  logic stall_out, dmem_req, dmem_we, wen_out, memtoreg_out, jal_out, bus_err_out, misalign_out;
  logic [DW-1:0] dmem_addr, dmem_wdata, aluout_out, memdata_out;
  logic [RAW-1:0] waddr_out;
  logic [PCW-1:0] nPC_out;
  always #5 clk = ~clk;
  mem_access_stage #(.DW(DW), .RAW(RAW), .PCW(PCW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .aluout_in(aluout_in), .wdata_in(wdata_in), .waddr_in(waddr_in),
    .wen_in(wen_in), .memread_in(memread_in), .memwrite_in(memwrite_in), .memtoreg_in(memtoreg_in),
    .jal_in(jal_in), .nPC_in(nPC_in), .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .waddr_out(waddr_out), .aluout_out(aluout_out), .memdata_out(memdata_out), .wen_out(wen_out),
    .memtoreg_out(memtoreg_out), .jal_out(jal_out), .nPC_out(nPC_out), .bus_err_out(bus_err_out),
    .misalign_out(misalign_out)
  );
  typedef struct {
    bit only_rst;
    logic stall, req, we, wen, m2r, jal, berr, mis;
    logic [DW-1:0] addr, wdata, aluout, memdata;
    logic [PCW-1:0] npc;
    logic [RAW-1:0] waddr;
  } exp_t;
  exp_t q[$];
  exp_t ce;
  int n_chk = 0, n_fail = 0, run = 0, last_run = 0, cyc = 0;
  logic [DW-1:0] lb = 0;
  logic c_rd = 0, c_wr = 0, c_wen = 0, c_m2r = 0, c_jal = 0, c_rst = 1;
  logic [DW-1:0] c_alu = 0, c_wd = 0;
  logic [RAW-1:0] c_wa = 0;
  logic [PCW-1:0] c_npc = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask
  function automatic exp_t pass();
    exp_t e;
    e.only_rst = 0; e.stall = 0; e.req = 0; e.we = 0; e.addr = 0; e.wdata = 0;
    e.aluout = c_alu; e.memdata = lb; e.npc = c_npc; e.waddr = c_wa;
    e.wen = c_wen; e.m2r = c_m2r; e.jal = c_jal; e.berr = 0; e.mis = 0;
    return e;
  endfunction
  function automatic exp_t bubble();
    exp_t e = pass();
    e.wen = 0; e.m2r = 0; e.jal = 0;
    return e;
  endfunction
  function automatic exp_t stalled();
    exp_t e = bubble();
    e.stall = 1; e.req = 1; e.we = c_wr; e.addr = {c_alu[DW-1:2], 2'b00}; e.wdata = c_wd;
    return e;
  endfunction
  function automatic exp_t rst_rec();
    exp_t e = pass();
    e.only_rst = 1;
    return e;
  endfunction
  task automatic set_i(input logic rd, input logic wr, input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                       input logic [RAW-1:0] wa, input logic wen, input logic m2r, input logic jal,
                       input logic [PCW-1:0] npc);
    c_rd = rd; c_wr = wr; c_alu = alu; c_wd = wd; c_wa = wa; c_wen = wen; c_m2r = m2r; c_jal = jal; c_npc = npc;
  endtask
  task automatic tick(input logic ack, input logic [DW-1:0] rd, input exp_t e);
    @(posedge clk); #1;
    rst = c_rst; memread_in = c_rd; memwrite_in = c_wr; aluout_in = c_alu; wdata_in = c_wd;
    waddr_in = c_wa; wen_in = c_wen; memtoreg_in = c_m2r; jal_in = c_jal; nPC_in = c_npc;
    dmem_ack = ack; dmem_rdata = rd;
    q.push_back(e);
  endtask
  // d = cycle index (0 = first stall cycle) at which ack arrives; d < 0 means never
  task automatic access(input int d);
    logic [DW-1:0] rv;
    exp_t e;
    rv = 0;
`ifdef MEM_ALIGN_CHECK_EN
    if (c_alu[1:0] != 2'b00) begin
      e = bubble(); e.mis = 1;
      tick(1'($urandom), $urandom, e);
      return;
    end
`endif
    if (d < 0) begin
      for (int i = 0; i < TIMEOUT; i++) tick(1'b0, $urandom, stalled());
      e = bubble(); e.berr = 1;
      tick(1'($urandom), $urandom, e);
    end else begin
      for (int i = 0; i <= d; i++) begin
        rv = $urandom;
        tick(i == d, rv, stalled());
      end
      if (c_rd) lb = rv;
      tick(1'($urandom), $urandom, pass());
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (stall_out === 1'b1) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
    if (q.size() > 0) begin
      ce = q.pop_front();
      chk("req", dmem_req, ce.req);
      chk("stall", stall_out, ce.stall);
      chk("bus_err", bus_err_out, ce.berr);
      chk("misalign", misalign_out, ce.mis);
      if (!ce.only_rst) begin
        chk("aluout", aluout_out, ce.aluout);
        chk("waddr", waddr_out, ce.waddr);
        chk("npc", nPC_out, ce.npc);
        chk("memdata", memdata_out, ce.memdata);
        chk("wen", wen_out, ce.wen);
        chk("memtoreg", memtoreg_out, ce.m2r);
        chk("jal", jal_out, ce.jal);
        if (ce.req) begin
          chk("we", dmem_we, ce.we);
          chk("addr", dmem_addr, ce.addr);
          chk("wdata", dmem_wdata, ce.wdata);
        end
      end
    end
  end
  initial begin
    repeat (3) tick(1'b0, 0, rst_rec());
    c_rst = 0;
    set_i(0, 0, 32'h1234, 0, 5, 1, 0, 0, 32'h100);
    tick(1'b1, 32'h55, pass());
    @(negedge clk); #1;
    chk("pin_nonmem_alu", aluout_out, 32'h1234);
    chk("pin_nonmem_wen", wen_out, 1);
    chk("pin_nonmem_req", dmem_req, 0);
    set_i(1, 0, 32'h40, 0, 3, 1, 1, 0, 32'h104);
    tick(1'b1, 32'hDEADBEEF, stalled());
    lb = 32'hDEADBEEF;
    tick(1'b0, 0, pass());
    @(negedge clk); #1;
    chk("pin_load_data", memdata_out, 32'hDEADBEEF);
    chk("pin_load_m2r", memtoreg_out, 1);
    chk("pin_load_stalls", last_run, 1);
    set_i(0, 1, 32'h80, 32'hA5A5A5A5, 0, 0, 0, 0, 32'h108);
    for (int i = 0; i < 4; i++) tick(i == 3, $urandom, stalled());
    tick(1'b0, 0, pass());
    @(negedge clk); #1;
    chk("pin_store_stalls", last_run, 4);
    chk("pin_store_lb", memdata_out, 32'hDEADBEEF);
    set_i(1, 0, 32'h100, 0, 7, 1, 1, 0, 32'h10C);
    access(-1);
    @(negedge clk); #1;
    chk("pin_to_berr", bus_err_out, 1);
    chk("pin_to_wen", wen_out, 0);
    chk("pin_to_stalls", last_run, TIMEOUT);
    set_i(0, 0, 32'h9, 0, 2, 1, 0, 0, 32'h110);
    tick(1'b0, 32'h11111111, pass());
    tick(1'b1, 32'h11111111, pass());
    @(negedge clk); #1;
    chk("pin_late_ack", memdata_out, 32'hDEADBEEF);
    set_i(1, 0, 32'h200, 0, 4, 1, 1, 0, 32'h114);
    tick(1'b0, 0, stalled());
    tick(1'b0, 0, stalled());
    c_rst = 1;
    tick(1'b1, 32'h77777777, rst_rec());
    c_rst = 0;
    lb = 0;
    set_i(0, 0, 32'h300, 0, 1, 1, 0, 1, 32'h118);
    tick(1'b0, 0, pass());
    @(negedge clk); #1;
    chk("pin_rst_req", dmem_req, 0);
    chk("pin_rst_stall", stall_out, 0);
    chk("pin_rst_lb", memdata_out, 0);
    set_i(1, 0, 32'h42, 0, 6, 1, 1, 0, 32'h11C);
`ifdef MEM_ALIGN_CHECK_EN
    access(0);
    @(negedge clk); #1;
    chk("pin_mis_pulse", misalign_out, 1);
    chk("pin_mis_stall", stall_out, 0);
    chk("pin_mis_wen", wen_out, 0);
`else
    tick(1'b1, 32'h0BADF00D, stalled());
    @(negedge clk); #1;
    chk("pin_mis_addr", dmem_addr, 32'h40);
    lb = 32'h0BADF00D;
    tick(1'b0, 0, pass());
`endif
    set_i(1, 0, 32'h44, 0, 6, 1, 1, 0, 32'h120);
    access(TIMEOUT - 1);
    @(negedge clk); #1;
    chk("pin_lastack_stalls", last_run, TIMEOUT);
    chk("pin_lastack_berr", bus_err_out, 0);
    repeat (300) begin
      int k, d;
      k = $urandom % 10;
      d = ($urandom % 4 == 0) ? int'($urandom % TIMEOUT) : int'($urandom % 3);
      set_i(k inside {[4:6]} || k == 9, k inside {[7:8]}, $urandom, $urandom, RAW'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      if (k < 4) tick(1'($urandom), $urandom, pass());
      else access(k == 9 ? -1 : d);
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
